proc_run_ctrl: RTL
==================

// Module: proc_run_ctrl
// PURPOSE
//   Run controller for the single-cycle processor: loads instruction memory from a byte stream, then starts, freezes and halts the core.
//   Sits between a host/loader byte interface and the core (PC, register file, data memory enables, instruction memory write port).
//   Holds the core in reset while programming; stops the PC on the HALT opcode so the halt instruction remains at pc.
// PARAMETERS
//   ADDR_W       8      instruction memory address width (matches PC width)
//   HALT_OPCODE  4'hF   opcode that halts the core
// PORTS
//   clk          in   1       system clock, all state on rising edge
//   rst          in   1       asynchronous, active-low reset
//   ld_start     in   1       pulse: begin program load (accepted in IDLE or HALT only)
//   ld_count     in   ADDR_W  number of 16-bit words to load; 0 = no-op
//   byte_valid   in   1       loader byte valid
//   byte_data    in   8       loader byte; low byte of each word first
//   byte_ready   out  1       controller accepts byte this cycle
//   imem_we      out  1       instruction memory write strobe (1 cycle per word)
//   imem_waddr   out  ADDR_W  instruction memory write address
//   imem_wdata   out  16      instruction word {hi,lo}
//   run_req      in   1       pulse: start/resume core
//   halt_req     in   1       pulse: stop core
//   instr_opcode in   4       opcode of instruction at current pc (from decoder)
//   core_en      out  1       PC/RegWrite/MemWrite qualifier
//   core_rst_n   out  1       active-low reset to PC/regfile/data memory
//   busy         out  1       load in progress
//   halted       out  1       core stopped by HALT opcode or halt_req
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; byte_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_rst_n=0, busy=0, halted=0.
//   States: IDLE, LOAD_LO, LOAD_HI, RUN, HALT. All outputs are registered except core_en and byte_ready.
//   core_en = (state==RUN) && (instr_opcode != HALT_OPCODE), combinational; the PC never advances past HALT.
//   byte_ready = (state==LOAD_LO || state==LOAD_HI).
//   IDLE/HALT: on ld_start with ld_count!=0, latch count, clear word counter, set imem_waddr=0, core_rst_n=0, busy=1, halted=0 -> LOAD_LO.
//     On ld_start with ld_count==0, no state change. ld_start has priority over a simultaneous run_req.
//   LOAD_LO: on byte_valid&&byte_ready, capture lo byte -> LOAD_HI.
//   LOAD_HI: on handshake, imem_wdata={byte_data,lo} and imem_we=1 in the next cycle at the current imem_waddr.
//     After the write, imem_waddr increments mod 2^ADDR_W. On the last word -> IDLE, busy=0; otherwise -> LOAD_LO.
//   Load latency: 1 cycle from hi-byte handshake to imem_we. Word throughput: 2 cycles with byte_valid held high.
//   IDLE: on run_req, core_rst_n=1 -> RUN. Execution starts at pc=0 because core_rst_n was released from 0.
//   RUN: if instr_opcode==HALT_OPCODE or halt_req, next state HALT, halted=1. halt_req and HALT opcode together produce one HALT.
//     ld_start is ignored in RUN.
//   HALT: core_en=0, core_rst_n stays 1, so register and memory contents are preserved.
//     On run_req -> RUN; if the opcode is still HALT, this re-halts next cycle.
//   ld_start and run_req are ignored in LOAD_*. A dropped byte_valid simply stalls.
//   Reset mid-load discards the partial word and the remaining count; the words already written stay in memory.
// CONFIGURATION
//   SIMPLEPROC_STEP_EN defined: adds input step_req (pulse) and output step_ack.
//     In HALT, step_req with opcode!=HALT_OPCODE forces core_en=1 for exactly one cycle, then returns to HALT.
//     step_ack pulses 1 cycle after the stepped cycle. step_req in any other state is ignored.
//   SIMPLEPROC_STEP_EN undefined: neither port exists and HALT leaves only on run_req or ld_start.
// STRUCTURE
//   Package simpleproc_pkg: ctrl_state_t (3-bit enum), INSTR_W=16, BYTE_W=8, OP_HALT=4'hF.
//   Package also holds opcode constants that are shared with the instruction decoder.
//   Sub-module ld_word_packer: lo/hi byte assembly and the write strobe/address counter. The FSM stays in proc_run_ctrl.
// TESTING
//   1. Reset mid-operation: assert rst low during LOAD_HI -> all outputs return to reset values at once; the next load restarts at addr 0.
//   2. Load: ld_count=3, bytes 34 12 78 56 BC 9A with valid held -> writes 1234@0, 5678@1, 9ABC@2, one cycle each; busy falls after the 3rd write.
//   3. Backpressure: deassert byte_valid for 5 cycles between lo and hi -> no write until the hi byte arrives; the word is correct.
//   4. Run/halt: run_req, then opcode=F at pc=4 -> core_en low in the same cycle, halted=1, pc holds at 4.
//   5. Priority and ignores: ld_start+run_req in IDLE -> LOAD_LO; ld_count=0 -> stays IDLE; halt_req in RUN -> HALT next cycle.
//   6. Step (SIMPLEPROC_STEP_EN): in HALT with opcode!=F, step_req -> core_en high for exactly 1 cycle, step_ack follows 1 cycle later.

Source files
------------

// File: rtl/simpleproc_pkg.sv
// Shared types and constants for the simple processor: run-controller states,
// instruction/byte widths and the opcode map used by the decoder.
package simpleproc_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned OPC_W   = 4;

  // Opcode map, shared with the instruction decoder
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h2;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h3;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'h4;
  localparam logic [OPC_W-1:0] OP_LW   = 4'h5;
  localparam logic [OPC_W-1:0] OP_SW   = 4'h6;
  localparam logic [OPC_W-1:0] OP_BEQ  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_LO = 3'd1,
    ST_LOAD_HI = 3'd2,
    ST_RUN     = 3'd3,
    ST_HALT    = 3'd4
  } ctrl_state_t;

  // Instruction words arrive low byte first; the word is {hi, lo}
  function automatic logic [INSTR_W-1:0] pack_word(input logic [BYTE_W-1:0] hi,
                                                   input logic [BYTE_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/ld_word_packer.sv
// Byte-to-word assembly for instruction memory loading: captures lo/hi bytes,
// issues a one-cycle write strobe and advances the write address after each write.
module ld_word_packer
  import simpleproc_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  count,
  input  logic               lo_hs,
  input  logic               hi_hs,
  input  logic [BYTE_W-1:0]  byte_data,
  output logic               last_word_c,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata
);

  logic [BYTE_W-1:0]  lo_q;
  logic [ADDR_W-1:0]  count_q;
  logic [ADDR_W-1:0]  word_cnt_q;
  logic               we_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [INSTR_W-1:0] wdata_q;

  // Current hi handshake completes the final word of the load
  assign last_word_c = (word_cnt_q == (count_q - ADDR_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q       <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      we_q <= hi_hs;
      if (start) begin
        count_q    <= count;
        word_cnt_q <= '0;
        waddr_q    <= '0;
      end else begin
        if (we_q)  waddr_q    <= waddr_q + ADDR_W'(1);
        if (hi_hs) word_cnt_q <= word_cnt_q + ADDR_W'(1);
      end
      if (lo_hs) lo_q    <= byte_data;
      if (hi_hs) wdata_q <= pack_word(byte_data, lo_q);
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller: loads instruction memory from a byte stream, then runs/halts the core.
// Optional single-step in HALT when SIMPLEPROC_STEP_EN is defined (adds step_req/step_ack).
module proc_run_ctrl
  import simpleproc_pkg::*;
#(
  parameter int unsigned      ADDR_W      = 8,
  parameter logic [OPC_W-1:0] HALT_OPCODE = OP_HALT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_start,
  input  logic [ADDR_W-1:0]  ld_count,
  input  logic               byte_valid,
  input  logic [BYTE_W-1:0]  byte_data,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  input  logic               run_req,
  input  logic               halt_req,
  input  logic [OPC_W-1:0]   instr_opcode,
  output logic               core_en,
  output logic               core_rst_n,
  output logic               busy,
`ifdef SIMPLEPROC_STEP_EN
  input  logic               step_req,
  output logic               step_ack,
`endif
  output logic               halted
);

  ctrl_state_t state_q, state_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;
  logic        pk_start, lo_hs, hi_hs, last_word_c;
  logic        ld_go_c, op_halt_c;
`ifdef SIMPLEPROC_STEP_EN
  logic        step_q, step_d, step_ack_q;
`endif

  assign ld_go_c   = ld_start && (ld_count != '0);
  assign op_halt_c = (instr_opcode == HALT_OPCODE);

  ld_word_packer #(.ADDR_W(ADDR_W)) u_packer (
    .clk         (clk),
    .rst         (rst),
    .start       (pk_start),
    .count       (ld_count),
    .lo_hs       (lo_hs),
    .hi_hs       (hi_hs),
    .byte_data   (byte_data),
    .last_word_c (last_word_c),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata)
  );

  // Next state and next values of the registered control outputs
  always_comb begin
    state_d      = state_q;
    core_rst_n_d = core_rst_n_q;
    busy_d       = busy_q;
    halted_d     = halted_q;
    pk_start     = 1'b0;
    lo_hs        = 1'b0;
    hi_hs        = 1'b0;
`ifdef SIMPLEPROC_STEP_EN
    step_d       = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (ld_go_c) begin
          pk_start     = 1'b1;
          core_rst_n_d = 1'b0;
          busy_d       = 1'b1;
          halted_d     = 1'b0;
          state_d      = ST_LOAD_LO;
        end else if (run_req) begin
          core_rst_n_d = 1'b1;
          halted_d     = 1'b0;
          state_d      = ST_RUN;
        end
`ifdef SIMPLEPROC_STEP_EN
        else if ((state_q == ST_HALT) && step_req && !step_q && !op_halt_c) begin
          step_d = 1'b1;
        end
`endif
      end
      ST_LOAD_LO: begin
        if (byte_valid && byte_ready) begin
          lo_hs   = 1'b1;
          state_d = ST_LOAD_HI;
        end
      end
      ST_LOAD_HI: begin
        if (byte_valid && byte_ready) begin
          hi_hs = 1'b1;
          if (last_word_c) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD_LO;
          end
        end
      end
      ST_RUN: begin
        if (op_halt_c || halt_req) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and core qualifier must act in the same cycle, so they stay combinational
  always_comb begin
    byte_ready = (state_q == ST_LOAD_LO) || (state_q == ST_LOAD_HI);
`ifdef SIMPLEPROC_STEP_EN
    core_en    = ((state_q == ST_RUN) && !op_halt_c) || step_q;
`else
    core_en    = (state_q == ST_RUN) && !op_halt_c;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
    end
  end

`ifdef SIMPLEPROC_STEP_EN
  // step_q is the stepped cycle; step_ack follows it by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q     <= 1'b0;
      step_ack_q <= 1'b0;
    end else begin
      step_q     <= step_d;
      step_ack_q <= step_q;
    end
  end

  assign step_ack = step_ack_q;
`endif

  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign halted     = halted_q;

endmodule
